// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares datamem between the Forth core and one external req/ack port.
// Optional stall statistics counter: define DMEM_ARB_STATS_EN.

`ifndef H
`define H 15
`endif

module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [`H:0]   c_addr,
   input  logic [`H:0]   c_wd,
   output logic [`H:0]   c_rd,
   output logic          c_stall,
   input  logic          x_req,
   input  logic          x_we,
   input  logic [`H:0]   x_addr,
   input  logic [`H:0]   x_wd,
   output logic [`H:0]   x_rd,
   output logic          x_ack,
   output logic          m_we,
   output logic [`H:0]   m_addr,
   output logic [`H:0]   m_wd,
   input  logic [`H:0]   m_rd
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   typedef enum logic {ST_ARB, ST_ACK} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_x_ack;
   logic [`H:0]   r_x_rd;

   logic          w_x_gnt;
   logic          w_c_gnt;
   logic          w_starved;

   assign w_starved = (r_cnt == LIMIT);

   // The ACK state makes the external port ineligible, so the core never stalls twice in a row.
   always_comb begin
      w_x_gnt = 1'b0;
      w_c_gnt = c_req;
      if (r_state == ST_ARB) begin
         w_x_gnt = x_req && (!c_req || w_starved);
         w_c_gnt = c_req && !w_x_gnt;
      end
   end

   always_comb begin
      m_addr = c_addr;
      m_wd   = c_wd;
      m_we   = c_we && w_c_gnt;
      if (w_x_gnt) begin
         m_addr = x_addr;
         m_wd   = x_wd;
         m_we   = x_we;
      end
   end

   assign c_rd    = m_rd;
   assign c_stall = c_req && !w_c_gnt;
   assign x_rd    = r_x_rd;
   assign x_ack   = r_x_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_ARB;
         r_x_ack <= 1'b0;
         r_x_rd  <= '0;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_x_gnt) begin
                  r_state <= ST_ACK;
                  r_x_ack <= 1'b1;
                  r_x_rd  <= m_rd;
               end else begin
                  r_x_ack <= 1'b0;
               end
            end
            ST_ACK: begin
               r_state <= ST_ARB;
               r_x_ack <= 1'b0;
            end
            default: begin
               r_state <= ST_ARB;
               r_x_ack <= 1'b0;
            end
         endcase
      end
   end

   // Counts contended core wins while an external request waits; reaching LIMIT forces it through.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 4'd0;
      end else if (w_x_gnt || !x_req) begin
         r_cnt <= 4'd0;
      end else if ((r_state == ST_ARB) && w_c_gnt && (r_cnt < LIMIT)) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= 16'd0;
      end else if (c_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed check of dmem_arbiter against a reference model.

`ifndef H
`define H 15
`endif

module tb_dmem_arbiter;

   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          c_req = 1'b0, c_we = 1'b0, x_req = 1'b0, x_we = 1'b0;
   logic [`H:0]   c_addr = '0, c_wd = '0, x_addr = '0, x_wd = '0;
   logic [`H:0]   c_rd, x_rd, m_addr, m_wd, m_rd;
   logic          c_stall, x_ack, m_we;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd), .c_rd(c_rd), .c_stall(c_stall),
      .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wd(x_wd), .x_rd(x_rd), .x_ack(x_ack),
      .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
`ifdef DMEM_ARB_STATS_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   // datamem stand-in: combinational read, synchronous write
   logic [`H:0] dm [0:255];
   assign m_rd = dm[m_addr[7:0]];
   always @(posedge clk) if (m_we) dm[m_addr[7:0]] <= m_wd;

   // reference model
   logic [`H:0] ref_mem [0:255];
   bit          md_ack;
   int          md_cnt;
   logic [`H:0] md_xrd;
   bit          e_stall;

   int n_vec = 0;
   int n_err = 0;

   logic          o_stall, o_mwe, o_xack;
   logic [`H:0]   o_maddr, o_crd, o_xrd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit rv, input bit cr, input bit cw, input logic [`H:0] ca,
                       input logic [`H:0] cd, input bit xr, input bit xw,
                       input logic [`H:0] xa, input logic [`H:0] xd);
      bit xg, cg, ewe;
      logic [`H:0] eaddr, ewd;
      @(negedge clk);
      reset = rv; c_req = cr; c_we = cw; c_addr = ca; c_wd = cd;
      x_req = xr; x_we = xw; x_addr = xa; x_wd = xd;
      if (rv) begin
         md_ack = 0; md_cnt = 0; md_xrd = '0;
      end
      xg = !md_ack && xr && (!cr || md_cnt == LIMIT);
      cg = cr && !xg;
      e_stall = cr && !cg;
      ewe   = xg ? xw : (cw && cg);
      eaddr = xg ? xa : ca;
      ewd   = xg ? xd : cd;
      #1;
      o_stall = c_stall; o_mwe = m_we; o_maddr = m_addr;
      o_crd = c_rd; o_xack = x_ack; o_xrd = x_rd;
      chk("c_stall", {31'd0, c_stall}, {31'd0, e_stall});
      chk("m_we", {31'd0, m_we}, {31'd0, ewe});
      chk("m_addr", 32'(m_addr), 32'(eaddr));
      if (ewe) chk("m_wd", 32'(m_wd), 32'(ewd));
      chk("x_ack", {31'd0, x_ack}, {31'd0, md_ack});
      chk("x_rd", 32'(x_rd), 32'(md_xrd));
      if (cg && !cw) chk("c_rd", 32'(c_rd), 32'(ref_mem[ca[7:0]]));
      @(posedge clk);
      if (rv) begin
         md_ack = 0; md_cnt = 0; md_xrd = '0;
      end else begin
         if (xg) md_xrd = ref_mem[xa[7:0]];
         if (xg || !xr) md_cnt = 0;
         else if (!md_ack && cg) md_cnt = (md_cnt + 1 > LIMIT) ? LIMIT : md_cnt + 1;
         md_ack = xg;
      end
      if (ewe) ref_mem[eaddr[7:0]] = ewd;
   endtask

   task automatic idle(input bit rv);
      step(rv, 0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   int wr_pulses;
   bit ext_pend, xw_r;
   logic [`H:0] xa_r, xd_r;
   bit cr_r, cw_r;
   logic [`H:0] ca_r, cd_r;

   initial begin
      for (int i = 0; i < 256; i++) begin
         dm[i] = '0; ref_mem[i] = '0;
      end
      md_ack = 0; md_cnt = 0; md_xrd = '0; e_stall = 0;

      idle(1); idle(1); idle(0);
      chk("reset_x_rd", 32'(o_xrd), 32'h0);
      chk("reset_x_ack", {31'd0, o_xack}, 32'h0);

      // core-only write then read
      step(0, 1, 1, 16'd5, 16'h1234, 0, 0, '0, '0);
      chk("core_wr_stall", {31'd0, o_stall}, 32'h0);
      step(0, 1, 0, 16'd5, '0, 0, 0, '0, '0);
      chk("core_rd_stall", {31'd0, o_stall}, 32'h0);
      chk("core_rd_data", 32'(o_crd), 32'h1234);

      // external-only read
      step(0, 0, 0, '0, '0, 1, 0, 16'd5, '0);
      chk("ext_gnt_mwe", {31'd0, o_mwe}, 32'h0);
      idle(0);
      chk("ext_ack", {31'd0, o_xack}, 32'h1);
      chk("ext_rd", 32'(o_xrd), 32'h1234);
      idle(0);
      chk("ext_ack_gone", {31'd0, o_xack}, 32'h0);

      // starvation: core holds request, external forced through on the 5th cycle
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 16'd1, '0, (i < 5), 0, 16'd2, '0);
         if (i < 4) chk("starve_core_win", {31'd0, o_stall}, 32'h0);
         if (i == 4) chk("starve_forced", {31'd0, o_stall}, 32'h1);
         if (i == 5) begin
            chk("starve_ack", {31'd0, o_xack}, 32'h1);
            chk("starve_ack_core", {31'd0, o_stall}, 32'h0);
         end
      end
      idle(0);

      // external write under contention
      wr_pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 16'd1, '0, (i < 5), 1, 16'd9, 16'hBEEF);
         if (o_mwe && o_maddr == 16'd9) wr_pulses++;
      end
      chk("xwr_pulses", 32'(wr_pulses), 32'd1);
      step(0, 1, 0, 16'd9, '0, 0, 0, '0, '0);
      chk("xwr_readback", 32'(o_crd), 32'hBEEF);

      // reset in the grant cycle, then reissue
      idle(0);
      step(1, 0, 0, '0, '0, 1, 0, 16'd9, '0);
      idle(0);
      chk("rst_no_ack", {31'd0, o_xack}, 32'h0);
      idle(0);
      chk("rst_no_ack2", {31'd0, o_xack}, 32'h0);
      step(0, 0, 0, '0, '0, 1, 0, 16'd9, '0);
      idle(0);
      chk("reissue_ack", {31'd0, o_xack}, 32'h1);
      chk("reissue_rd", 32'(o_xrd), 32'hBEEF);

`ifdef DMEM_ARB_STATS_EN
      idle(1); idle(0);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 6; i++) step(0, 1, 0, 16'd1, '0, (i < 5), 0, 16'd2, '0);
         idle(0);
      end
      #1;
      chk("stall_cnt_3", 32'(stall_cnt), 32'd3);
      idle(1);
      #1;
      chk("stall_cnt_rst", 32'(stall_cnt), 32'd0);
      idle(0);
`endif

      // randomized traffic
      ext_pend = 0; cr_r = 0; cw_r = 0; ca_r = '0; cd_r = '0;
      xw_r = 0; xa_r = '0; xd_r = '0;
      for (int n = 0; n < 1500; n++) begin
         if (md_ack) ext_pend = 0;
         if (!ext_pend && ($urandom % 3 == 0)) begin
            ext_pend = 1;
            xw_r = $urandom % 2;
            xa_r = 16'($urandom % 16);
            xd_r = 16'($urandom);
         end
         if (!e_stall) begin
            cr_r = ($urandom % 10) < 7;
            cw_r = $urandom % 2;
            ca_r = 16'($urandom % 16);
            cd_r = 16'($urandom);
         end
         step(0, cr_r, cw_r, ca_r, cd_r, ext_pend, xw_r, xa_r, xd_r);
         if (n % 500 == 499) idle(1);
         if (n % 500 == 499) ext_pend = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data memory between the Forth core and one external requester (debug/DMA port). Sits between the core's data-memory port and `datamem`. The core gets zero-latency access by default. External accesses are granted when the core is idle or after a bounded starvation count, and use a req/ack handshake. The core is stalled in any cycle it loses arbitration.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: max consecutive contended core grants before the external request is forced through (1..15).

Ports (data/address width `` `H+1 `` from `global.vh`):
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `c_req` in 1: core requests a data-memory access this cycle.
- `c_we` in 1: core write enable.
- `c_addr` in `` `H+1 ``: core address.
- `c_wd` in `` `H+1 ``: core write data.
- `c_rd` out `` `H+1 ``: core read data, combinational from `m_rd`.
- `c_stall` out 1: core must hold its request; high when `c_req` and not core-granted.
- `x_req` in 1: external request. Level signal, held with stable `x_we`/`x_addr`/`x_wd` until `x_ack`.
- `x_we` in 1: external write enable.
- `x_addr` in `` `H+1 ``: external address.
- `x_wd` in `` `H+1 ``: external write data.
- `x_rd` out `` `H+1 ``: registered external read data, valid while `x_ack`=1.
- `x_ack` out 1: one-cycle completion pulse.
- `m_we` out 1: to datamem write enable.
- `m_addr` out `` `H+1 ``: to datamem address.
- `m_wd` out `` `H+1 ``: to datamem write data.
- `m_rd` in `` `H+1 ``: from datamem, combinational read.

## Operation
- FSM with two states:
  - ARB: normal arbitration.
  - ACK: `x_ack`=1; the external port is ineligible this cycle.
- Arbitration in ARB (combinational):
  - `x_gnt` = `x_req` && (!`c_req` || `cnt` == `STARVE_LIMIT`).
  - `c_gnt` = `c_req` && !`x_gnt`.
- Arbitration in ACK: `x_gnt`=0 and `c_gnt`=`c_req`.
- Transitions: ARB→ACK on `x_gnt`; ACK→ARB unconditionally.
- Starvation counter `cnt` (4 bits):
  - Cleared when `x_gnt`=1 or `x_req`=0.
  - Incremented, saturating at `STARVE_LIMIT`, when in ARB with `x_req` && `c_gnt`.
- Memory mux:
  - `x_gnt`: `m_*` = `x_*`.
  - Otherwise `m_addr`=`c_addr`, `m_wd`=`c_wd`, `m_we`=`c_we` && `c_gnt`.
  - With no grant, `m_we`=0, so no spurious writes.
- On `x_gnt`, `x_rd` <= `m_rd` at the clock edge (captured for writes too).
- `c_rd` is always `m_rd`. It is meaningful only when `c_gnt`.
- The external requester must deassert `x_req` in the ack cycle or present its next request. A held request is not serviced until ARB.

## Timing
- Reset values: state=ARB, `cnt`=0, `x_ack`=0, `x_rd`=0.
  - Combinational outputs follow inputs under reset with the FSM in ARB.
- Core latency: 0 cycles when granted. Worst-case stall is 1 cycle per external access. Never 2 consecutive stall cycles, because ACK forbids an external grant.
- External latency:
  - `x_ack` exactly 1 cycle after the grant cycle.
  - Grant no later than `STARVE_LIMIT` contended cycles after `x_req` rises in ARB.
- Simultaneous `c_req` and `x_req` with `cnt`<`STARVE_LIMIT`: core wins.
- Reset mid-access: an in-flight external access gets no ack. A write granted in the reset cycle is not guaranteed. The requester reissues.
- Back-to-back external requests with the core idle: one access per 2 cycles.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - Adds output port `stall_cnt` [15:0].
  - Increments each cycle `c_stall`=1 and saturates at 16'hFFFF.
  - Cleared only by `reset`.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Core-only: `c_req`=1, `c_we`=1, `c_addr`=5, `c_wd`=0x1234, then a read of 5 → `c_stall`=0 throughout, `c_rd`=0x1234 same cycle.
- External-only: `x_req`=1, `x_we`=0, `x_addr`=5 with core idle → grant in cycle 0, `x_ack`=1 in cycle 1 with `x_rd`=0x1234, `x_ack`=0 in cycle 2.
- Starvation: `STARVE_LIMIT`=4, `c_req` held 1, `x_req` rises → core granted 4 cycles, external granted 5th with `c_stall`=1, `x_ack` 6th, core granted in the ack cycle.
- External write under contention: `x_we`=1, `x_addr`=9, `x_wd`=0xBEEF → exactly one `m_we` pulse with `m_addr`=9; a later core read of 9 returns 0xBEEF.
- Reset mid-access: assert `reset` in the external grant cycle → `x_ack` never pulses, state=ARB, `cnt`=0; a reissued request completes normally.
- With `DMEM_ARB_STATS_EN`: starvation scenario repeated 3 times → `stall_cnt`=3; reset → 0.
